// File: rtl/sweep_pkg.sv
// Shared types and default sizing for the triangular sweep sequencer.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP   = 3'd1,
        HOLD = 3'd2,
        DOWN = 3'd3,
        DONE = 3'd4
    } sweep_state_e;

    localparam int unsigned SWEEP_WIDTH   = 4;
    localparam int unsigned SWEEP_DWELL_W = 4;
    localparam int unsigned SWEEP_REP_W   = 4;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Command and status bundle between a command source and the sweep sequencer.
interface sweep_sequencer_if
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = SWEEP_WIDTH,
    parameter int unsigned DWELL_W = SWEEP_DWELL_W,
    parameter int unsigned REP_W   = SWEEP_REP_W
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_lo;
    logic [WIDTH-1:0]   cmd_hi;
    logic [DWELL_W-1:0] cmd_dwell;
    logic [REP_W-1:0]   cmd_reps;
    logic               abort;
    logic [WIDTH-1:0]   count;
    logic               dir_up;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd_lo, cmd_hi, cmd_dwell, cmd_reps, abort,
        input  cmd_ready, count, dir_up, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_lo, cmd_hi, cmd_dwell, cmd_reps, abort,
        output cmd_ready, count, dir_up, busy, done, err
    );

endinterface

// File: rtl/updown_counter_ld.sv
// Enabled, loadable up/down counter; load wins over enable, wraps modulo 2^WIDTH.
module updown_counter_ld
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH = SWEEP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (ld) begin
            count_d = d;
        end else if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sweep_sequencer.sv
// Sequences an up/down counter through programmed triangular sweeps lo->hi->lo.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = SWEEP_WIDTH,
    parameter int unsigned DWELL_W = SWEEP_DWELL_W,
    parameter int unsigned REP_W   = SWEEP_REP_W
) (
    input  logic               clk,
    input  logic               rst,
    sweep_sequencer_if.slave   bus
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [REP_W-1:0]   REP_ONE   = REP_W'(1);

    sweep_state_e       state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               flat_q, flat_d;
    logic               dir_q, dir_d;
    logic               err_q, err_d;

    logic               cnt_en;
    logic               cnt_up;
    logic               cnt_ld;
    logic [WIDTH-1:0]   cnt_val;
    logic [WIDTH-1:0]   cnt_inc;
    logic [WIDTH-1:0]   cnt_dec;

    assign cnt_inc = cnt_val + 1'b1;
    assign cnt_dec = cnt_val - 1'b1;

    updown_counter_ld #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (cnt_en),
        .up    (cnt_up),
        .ld    (cnt_ld),
        .d     (bus.cmd_lo),
        .count (cnt_val)
    );

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        reps_d      = reps_q;
        flat_d      = flat_q;
        dir_d       = dir_q;
        err_d       = 1'b0;
        cnt_en      = 1'b0;
        cnt_up      = 1'b1;
        cnt_ld      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_lo > bus.cmd_hi) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_ld  = 1'b1;
                        lo_d    = bus.cmd_lo;
                        hi_d    = bus.cmd_hi;
                        dwell_d = bus.cmd_dwell;
                        dir_d   = 1'b1;
                        reps_d  = (bus.cmd_reps == '0) ? REP_ONE : bus.cmd_reps;
                        flat_d  = (bus.cmd_lo == bus.cmd_hi);
                        if (bus.cmd_lo != bus.cmd_hi) begin
                            state_d = UP;
                        end else if (bus.cmd_dwell != '0) begin
                            dwell_cnt_d = bus.cmd_dwell;
                            state_d     = HOLD;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            UP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_inc == hi_q) begin
                        if (dwell_q != '0) begin
                            dwell_cnt_d = dwell_q;
                            state_d     = HOLD;
                        end else begin
                            dir_d   = 1'b0;
                            state_d = DOWN;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - 1'b1;
                    if (dwell_cnt_q == DWELL_ONE) begin
                        if (flat_q) begin
                            state_d = DONE;
                        end else begin
                            dir_d   = 1'b0;
                            state_d = DOWN;
                        end
                    end
                end
            end
            DOWN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b0;
                    if (cnt_dec == lo_q) begin
                        if (reps_q == REP_ONE) begin
                            state_d = DONE;
                        end else begin
                            reps_d  = reps_q - 1'b1;
                            dir_d   = 1'b1;
                            state_d = UP;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            reps_q      <= '0;
            flat_q      <= 1'b0;
            dir_q       <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            reps_q      <= reps_d;
            flat_q      <= flat_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
        end
    end

    // Handshake and status come straight off the state register.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
    assign bus.dir_up    = dir_q;
    assign bus.count     = cnt_val;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench: directed and random sweeps against a trajectory model.
module tb_sweep_sequencer;
    import sweep_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned RW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sweep_sequencer_if #(.WIDTH(W), .DWELL_W(DW), .REP_W(RW)) bus ();

    sweep_sequencer #(.WIDTH(W), .DWELL_W(DW), .REP_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total   = 0;
    int n_pass    = 0;
    int model_cnt = 0;

    // Expected per-cycle count/dir_up after the accept edge, built from the sweep rules.
    task automatic run_sweep(input int lo, input int hi, input int dwell,
                             input int reps, input int abort_at);
        int   exp_c[$];
        bit   exp_d[$];
        int   passes;
        int   last;
        logic [7:0] got8, want8;
        logic [6:0] got, want;

        bus.cmd_lo    = W'(lo);
        bus.cmd_hi    = W'(hi);
        bus.cmd_dwell = DW'(dwell);
        bus.cmd_reps  = RW'(reps);
        bus.cmd_valid = 1'b1;

        if (lo > hi) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            n_total++;
            got8  = {bus.err, bus.cmd_ready, bus.busy, bus.done, bus.count};
            want8 = {1'b1, 1'b1, 1'b0, 1'b0, W'(model_cnt)};
            if (got8 !== want8) $display("FAIL bad_range lo=%0d hi=%0d: err,rdy,busy,done,count got %b want %b", lo, hi, got8, want8);
            else n_pass++;
            @(negedge clk);
            n_total++;
            got8  = {bus.err, bus.cmd_ready, bus.busy, bus.done, bus.count};
            want8 = {1'b0, 1'b1, 1'b0, 1'b0, W'(model_cnt)};
            if (got8 !== want8) $display("FAIL bad_range_clear lo=%0d hi=%0d: got %b want %b", lo, hi, got8, want8);
            else n_pass++;
            return;
        end

        exp_c.push_back(lo);
        exp_d.push_back(1'b1);
        if (lo == hi) begin
            repeat (dwell) begin
                exp_c.push_back(lo);
                exp_d.push_back(1'b1);
            end
        end else begin
            passes = (reps == 0) ? 1 : reps;
            for (int p = 0; p < passes; p++) begin
                for (int v = lo + 1; v < hi; v++) begin
                    exp_c.push_back(v);
                    exp_d.push_back(1'b1);
                end
                repeat (dwell) begin
                    exp_c.push_back(hi);
                    exp_d.push_back(1'b1);
                end
                exp_c.push_back(hi);
                exp_d.push_back(1'b0);
                for (int v = hi - 1; v > lo; v--) begin
                    exp_c.push_back(v);
                    exp_d.push_back(1'b0);
                end
                exp_c.push_back(lo);
                exp_d.push_back((p == passes - 1) ? 1'b0 : 1'b1);
            end
        end
        last = exp_c.size() - 1;

        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (i == 0) bus.cmd_valid = 1'b0;
            n_total++;
            got  = {bus.count, bus.dir_up, bus.done, bus.busy};
            want = {W'(exp_c[i]), exp_d[i], (i == last), 1'b1};
            if (got !== want || bus.err !== 1'b0)
                $display("FAIL sweep lo=%0d hi=%0d dw=%0d rp=%0d step %0d: count,dir,done,busy got %b want %b (err=%b)",
                         lo, hi, dwell, reps, i, got, want, bus.err);
            else n_pass++;
            if (i == abort_at && i < last) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
                n_total++;
                got  = {bus.count, bus.dir_up, bus.done, bus.busy};
                want = {W'(exp_c[i]), exp_d[i], 1'b0, 1'b0};
                if (got !== want || bus.cmd_ready !== 1'b1)
                    $display("FAIL abort lo=%0d hi=%0d step %0d: count,dir,done,busy got %b want %b (rdy=%b)",
                             lo, hi, i, got, want, bus.cmd_ready);
                else n_pass++;
                model_cnt = exp_c[i];
                return;
            end
            if (i == abort_at) bus.abort = 1'b1;
        end

        @(negedge clk);
        bus.abort = 1'b0;
        n_total++;
        got8  = {bus.cmd_ready, bus.busy, bus.done, bus.err, W'(bus.count)};
        want8 = {1'b1, 1'b0, 1'b0, 1'b0, W'(lo)};
        if (got8 !== want8) $display("FAIL sweep_idle lo=%0d hi=%0d: rdy,busy,done,err,count got %b want %b", lo, hi, got8, want8);
        else n_pass++;
        model_cnt = lo;
    endtask

    task automatic test_reset();
        logic [8:0] got, want;
        want = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        repeat (2) @(negedge clk);
        n_total++;
        got = {bus.count, bus.cmd_ready, bus.busy, bus.done, bus.err, bus.dir_up};
        if (got !== want) $display("FAIL reset_held: count,rdy,busy,done,err,dir got %b want %b", got, want);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            got = {bus.count, bus.cmd_ready, bus.busy, bus.done, bus.err, bus.dir_up};
            if (got !== want) $display("FAIL idle_stable cycle %0d: got %b want %b", i, got, want);
            else n_pass++;
        end
        model_cnt = 0;
    endtask

    task automatic test_basic_sweep();
        run_sweep(2, 5, 2, 1, -1);
    endtask

    task automatic test_full_range();
        run_sweep(0, 15, 0, 2, -1);
    endtask

    task automatic test_bad_range();
        run_sweep(9, 4, 1, 1, -1);
    endtask

    task automatic test_abort();
        run_sweep(3, 12, 1, 1, 4);
        run_sweep(1, 4, 0, 1, -1);
    endtask

    task automatic test_async_reset_flat();
        logic [7:0] got, want;
        bus.cmd_lo = 4'd2; bus.cmd_hi = 4'd9; bus.cmd_dwell = 4'd1; bus.cmd_reps = 4'd1;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_total++;
        if (bus.count !== 4'd7 || bus.dir_up !== 1'b0)
            $display("FAIL pre_reset_down: count got %0d want 7, dir got %b want 0", bus.count, bus.dir_up);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        got  = {bus.count, bus.cmd_ready, bus.busy, bus.done, bus.dir_up};
        want = {4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        if (got !== want) $display("FAIL async_reset: count,rdy,busy,done,dir got %b want %b", got, want);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0 || bus.count !== 4'd0)
            $display("FAIL post_reset_idle: busy got %b want 0, count got %0d want 0", bus.busy, bus.count);
        else n_pass++;
        run_sweep(6, 6, 3, 5, -1);
    endtask

    task automatic test_back_to_back();
        run_sweep(1, 3, 1, 3, -1);
        run_sweep(4, 4, 0, 0, -1);
        run_sweep(0, 1, 0, 2, -1);
        run_sweep(14, 15, 2, 1, 3);
        run_sweep(5, 8, 0, 1, 6);
    endtask

    task automatic test_random();
        int lo, hi, dw, rp, ab;
        for (int n = 0; n < 30; n++) begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(0, 15);
            if ($urandom_range(0, 5) == 0) hi = lo;
            dw = $urandom_range(0, 3);
            rp = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep(lo, hi, dw, rp, ab);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_lo    = '0;
        bus.cmd_hi    = '0;
        bus.cmd_dwell = '0;
        bus.cmd_reps  = '0;
        bus.abort     = 1'b0;

        test_reset();
        test_basic_sweep();
        test_full_range();
        test_bad_range();
        test_abort();
        test_async_reset_flat();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
Controller that sequences an up/down counter through programmed triangular sweeps. Each command sets a range [lo, hi], a dwell time at hi and a repeat count. The block loads the counter to lo, ramps up to hi, holds, then ramps down to lo, and repeats. It sits between a command source (valid/ready) and the counter datapath, and exposes the live count to downstream consumers.

Parameters:
WIDTH, 4, counter width in bits
DWELL_W, 4, width of dwell field (hold cycles at hi)
REP_W, 4, width of repeat-count field

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_lo  in  WIDTH  sweep lower bound
cmd_hi  in  WIDTH  sweep upper bound
cmd_dwell  in  DWELL_W  hold cycles at hi (0 = no hold)
cmd_reps  in  REP_W  number of up/down passes (0 treated as 1)
abort  in  1  terminate current sweep
count  out  WIDTH  current counter value
dir_up  out  1  1 = ramping up or loaded, 0 = ramping down
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected command (lo > hi)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset values: state=IDLE, count=0, cmd_ready=1, busy=0, done=0, err=0, dir_up=1, internal rep/dwell counters=0.
- States: IDLE, UP, HOLD, DOWN, DONE.
- Accept means cmd_valid & cmd_ready at an edge, which can only occur in IDLE. Command fields are latched at the accept edge.
- Accept with lo > hi: err=1 for the next cycle, state stays IDLE, count unchanged.
- Accept with lo < hi: at the same edge count<=lo, dir_up<=1, reps_left<=max(cmd_reps,1), next state UP.
- Accept with lo == hi: count<=lo, then HOLD for dwell cycles, then DONE. reps is ignored.
- UP: count<=count+1 each edge. When count+1 == hi, go to HOLD if dwell>0, otherwise go to DOWN. On entering HOLD, dwell_cnt<=dwell.
- HOLD: count is held. dwell_cnt decrements each edge. When dwell_cnt==1, exit to DOWN (or to DONE in the lo==hi case). HOLD lasts exactly dwell cycles.
- DOWN: dir_up=0, count<=count-1 each edge. When count-1 == lo:
  - reps_left==1: go to DONE.
  - otherwise: reps_left<=reps_left-1, dir_up<=1, go to UP.
- DONE: done=1 for exactly one cycle, count holds lo, next state IDLE (cmd_ready=1 again).
- abort=1 in UP, HOLD or DOWN: at the next edge go to IDLE. count freezes at its current value, no done, no err. abort has priority over all other transitions. abort in IDLE or DONE is ignored.
- The counter never wraps under control: ranges 0..15 hit both extremes without passing through them. The sub-module itself wraps modulo 2^WIDTH.
- Outputs are registered. cmd_ready and busy are decoded directly from the state register.
- Latency (lo=2, hi=5, dwell=2, reps=1), accept at edge 0:
  - count is 2,3,4,5 at edges 0-3.
  - HOLD occupies edges 3-5.
  - count is 4,3,2 at edges 6-8.
  - done is high after edge 8.
  - IDLE after edge 9.
- rst asserted mid-sweep: immediate return to reset values, and any latched command is discarded.

Decomposition:
- Package sweep_pkg holds the state enum (IDLE, UP, HOLD, DOWN, DONE) and the default WIDTH, DWELL_W and REP_W constants.
- One sub-module, updown_counter_ld: enabled, loadable up/down counter with ports clk, rst, en, up, ld, d, count. Load has priority over enable. The FSM drives en, up and ld; count is taken directly from this instance.

Test Plan:
- Reset release then idle: count=0, cmd_ready=1, busy=0, done=0; remains stable for 5 cycles with cmd_valid=0.
- Command lo=2, hi=5, dwell=2, reps=1 -> count sequence 2,3,4,5,5,5,4,3,2; done pulses once 8 cycles after accept; cmd_ready returns 1 the following cycle.
- Command lo=0, hi=15, dwell=0, reps=2 -> two full ramps 0→15→0 with no hold and no wrap; exactly one done pulse, after the second return to 0.
- Command lo=9, hi=4 -> err pulse for 1 cycle, no state change, count unchanged, cmd_ready stays 1.
- Command lo=3, hi=12, abort asserted when count=7 in UP -> next cycle IDLE, count=7, no done; a new command is accepted afterwards.
- rst asserted asynchronously mid-DOWN (between edges) -> count=0 and cmd_ready=1 immediately without a clock edge; degenerate command lo=hi=6, dwell=3 -> count=6 held 3 HOLD cycles, then done.
